// File: rtl/rtm_dram_loader.sv
`default_nettype none
// =============================================================================
// rtm_dram_loader : slices a DRAM read stream into per-beat RTM slice-group
//                   writes on the DRAM port of the RTM write controller.
// Revision        : 1.0
// =============================================================================
module rtm_dram_loader #(
   parameter  int S         = 8,
   parameter  int R         = 16,
   parameter  int RTM_DEPTH = 4096,
   parameter  int DW        = 512,
   localparam int AW        = $clog2(RTM_DEPTH),
   localparam int SW        = R * 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [AW-1:0]     base_addr,
   input  logic [15:0]       n_rows,
   output logic              busy,
   output logic              done,
   input  logic [DW-1:0]     s_tdata,
   input  logic              s_tvalid,
   output logic              s_tready,
   output logic              wr_vld_dram,
   output logic [S-1:0]      wr_en_dram,
   output logic [S*AW-1:0]   wr_addr_dram,
   output logic [S*SW-1:0]   din_dram
);

   localparam int K  = (S * SW) / DW;
   localparam int G  = S / K;
   localparam int KW = (K > 1) ? $clog2(K) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [15:0]     nrows_q, nrows_d;
   logic [15:0]     row_q, row_d;
   logic [KW-1:0]   beat_q, beat_d;
   logic            busy_q, busy_d;
   logic            tready_q, tready_d;
   logic            done_q, done_d;
   logic            wr_vld_q, wr_vld_d;
   logic [S-1:0]    wr_en_q, wr_en_d;
   logic [S*AW-1:0] wr_addr_q, wr_addr_d;
   logic [S*SW-1:0] din_q, din_d;
   logic            hs;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      nrows_d   = nrows_q;
      row_d     = row_q;
      beat_d    = beat_q;
      done_d    = 1'b0;
      hs        = (state_q == ST_LOAD) && s_tvalid;
      wr_vld_d  = hs;
      wr_en_d   = '0;
      wr_addr_d = wr_addr_q;
      din_d     = din_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               addr_d  = base_addr;
               nrows_d = n_rows;
               row_d   = '0;
               beat_d  = '0;
               if (n_rows == 16'd0) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            if (hs) begin
               // Beat j fills slice group j; every other slice lane reads zero.
               din_d     = '0;
               wr_addr_d = {S{addr_q}};
               for (int j = 0; j < K; j++) begin
                  if (beat_q == KW'(j)) begin
                     wr_en_d[j*G +: G] = '1;
                     din_d[j*DW +: DW] = s_tdata;
                  end
               end
               if (beat_q == KW'(K - 1)) begin
                  beat_d = '0;
                  row_d  = row_q + 16'd1;
                  addr_d = (addr_q == AW'(RTM_DEPTH - 1)) ? '0 : addr_q + AW'(1);
                  if (row_q == nrows_q - 16'd1) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end
               end else begin
                  beat_d = beat_q + KW'(1);
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      busy_d   = (state_d == ST_LOAD);
      tready_d = (state_d == ST_LOAD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         nrows_q   <= '0;
         row_q     <= '0;
         beat_q    <= '0;
         busy_q    <= 1'b0;
         tready_q  <= 1'b0;
         done_q    <= 1'b0;
         wr_vld_q  <= 1'b0;
         wr_en_q   <= '0;
         wr_addr_q <= '0;
         din_q     <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         nrows_q   <= nrows_d;
         row_q     <= row_d;
         beat_q    <= beat_d;
         busy_q    <= busy_d;
         tready_q  <= tready_d;
         done_q    <= done_d;
         wr_vld_q  <= wr_vld_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         din_q     <= din_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign s_tready     = tready_q;
   assign wr_vld_dram  = wr_vld_q;
   assign wr_en_dram   = wr_en_q;
   assign wr_addr_dram = wr_addr_q;
   assign din_dram     = din_q;

endmodule
`default_nettype wire

// File: tb/tb_rtm_dram_loader.sv
`default_nettype none
// =============================================================================
// tb_rtm_dram_loader : randomized self-checking bench with a beat-count model.
// Revision           : 1.0
// =============================================================================
module tb_rtm_dram_loader;

   localparam int S         = 8;
   localparam int R         = 16;
   localparam int RTM_DEPTH = 4096;
   localparam int DW        = 512;
   localparam int AW        = 12;
   localparam int SW        = R * 8;
   localparam int K         = (S * SW) / DW;
   localparam int G         = S / K;

   logic              clk = 1'b0;
   logic              rst, start, s_tvalid;
   logic [AW-1:0]     base_addr;
   logic [15:0]       n_rows;
   logic [DW-1:0]     s_tdata;
   logic              busy, done, s_tready, wr_vld_dram;
   logic [S-1:0]      wr_en_dram;
   logic [S*AW-1:0]   wr_addr_dram;
   logic [S*SW-1:0]   din_dram;

   rtm_dram_loader #(.S(S), .R(R), .RTM_DEPTH(RTM_DEPTH), .DW(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .n_rows(n_rows),
      .busy(busy), .done(done), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
      .s_tready(s_tready), .wr_vld_dram(wr_vld_dram), .wr_en_dram(wr_en_dram),
      .wr_addr_dram(wr_addr_dram), .din_dram(din_dram)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   bit chk_en = 1'b0;
   int start_cyc;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: tracks the command only as beats remaining / consumed.
   int m_remaining = 0;
   int m_consumed  = 0;
   int m_base      = 0;
   bit m_done_cyc  = 1'b0;
   logic              exp_busy, exp_done, exp_tready, exp_vld;
   logic [S-1:0]      exp_en;
   logic [S*AW-1:0]   exp_addr;
   logic [S*SW-1:0]   exp_din;

   always @(posedge clk) begin
      if (rst) begin
         m_remaining = 0;
         m_done_cyc  = 1'b0;
         exp_vld = 1'b0; exp_en = '0; exp_addr = '0; exp_din = '0; exp_done = 1'b0;
      end else begin
         exp_vld  = 1'b0;
         exp_en   = '0;
         exp_done = 1'b0;
         if (m_remaining > 0) begin
            if (s_tvalid) begin
               int b, r;
               b = m_consumed % K;
               r = m_consumed / K;
               exp_vld = 1'b1;
               for (int g = 0; g < G; g++) exp_en[b*G + g] = 1'b1;
               exp_din = '0;
               exp_din[b*DW +: DW] = s_tdata;
               for (int i = 0; i < S; i++) exp_addr[i*AW +: AW] = AW'((m_base + r) % RTM_DEPTH);
               m_consumed++;
               m_remaining--;
               if (m_remaining == 0) begin
                  exp_done   = 1'b1;
                  m_done_cyc = 1'b1;
               end
            end
         end else if (m_done_cyc) begin
            m_done_cyc = 1'b0;
         end else if (start) begin
            m_base      = int'(base_addr);
            m_consumed  = 0;
            m_remaining = int'(n_rows) * K;
            if (n_rows == 16'd0) begin
               exp_done   = 1'b1;
               m_done_cyc = 1'b1;
            end
         end
      end
      exp_busy   = (m_remaining > 0);
      exp_tready = (m_remaining > 0);
   end

   int          wr_cyc[$];
   logic [S-1:0] wr_en_log[$];
   logic [AW-1:0] wr_addr_log[$];
   logic [SW-1:0] s4_log[$];
   int          done_log[$];

   always @(negedge clk) begin
      if (chk_en) begin
         check("s_tready", 128'(s_tready), 128'(exp_tready));
         check("busy", 128'(busy), 128'(exp_busy));
         check("done", 128'(done), 128'(exp_done));
         check("wr_vld", 128'(wr_vld_dram), 128'(exp_vld));
         check("wr_en", 128'(wr_en_dram), 128'(exp_en));
         check("wr_addr", 128'(wr_addr_dram), 128'(exp_addr));
         for (int i = 0; i < S; i++)
            check($sformatf("din_s%0d", i), din_dram[i*SW +: SW], exp_din[i*SW +: SW]);
         if (wr_vld_dram) begin
            wr_cyc.push_back(cyc);
            wr_en_log.push_back(wr_en_dram);
            wr_addr_log.push_back(wr_addr_dram[AW-1:0]);
            s4_log.push_back(din_dram[4*SW +: SW]);
         end
         if (done) done_log.push_back(cyc);
      end
   end

   function automatic logic [DW-1:0] rand_beat();
      logic [DW-1:0] v;
      for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   task automatic clear_logs();
      wr_cyc.delete(); wr_en_log.delete(); wr_addr_log.delete(); s4_log.delete(); done_log.delete();
   endtask

   task automatic cmd(input int b, input int n);
      base_addr = b[AW-1:0];
      n_rows    = n[15:0];
      start     = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      start     = 1'b0;
      base_addr = AW'($urandom());
      n_rows    = 16'($urandom());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         s_tvalid = 1'($urandom_range(0, 1));
         s_tdata  = rand_beat();
         @(negedge clk);
      end
      s_tvalid = 1'b0;
   endtask

   // mode 0: continuous, 1: valid every third cycle, 2: random valid
   task automatic run_stream(input int mode, input logic [DW-1:0] pat, input bit use_pat,
                             input int inj_at, input int rst_after);
      int cnt = 0;
      while (m_remaining > 0) begin
         if (cnt >= 400) begin
            check("stream_timeout", 128'(m_remaining), 128'(0));
            break;
         end
         if (rst_after >= 0 && m_consumed == rst_after) begin
            rst      = 1'b1;
            s_tvalid = 1'b1;
            s_tdata  = rand_beat();
            @(negedge clk);
            rst      = 1'b0;
            s_tvalid = 1'b0;
            check("rst_busy", 128'(busy), 128'(0));
            check("rst_tready", 128'(s_tready), 128'(0));
            check("rst_done", 128'(done), 128'(0));
            check("rst_vld", 128'(wr_vld_dram), 128'(0));
            check("rst_en", 128'(wr_en_dram), 128'(0));
            check("rst_addr", 128'(wr_addr_dram), 128'(0));
            check("rst_din_zero", 128'(din_dram == '0), 128'(1));
            break;
         end
         case (mode)
            0:       s_tvalid = 1'b1;
            1:       s_tvalid = (cnt % 3 == 0);
            default: s_tvalid = ($urandom_range(0, 3) != 0);
         endcase
         s_tdata = use_pat ? pat : rand_beat();
         start   = (cnt == inj_at);
         if (start) begin
            base_addr = AW'(100);
            n_rows    = 16'd7;
         end
         @(negedge clk);
         cnt++;
      end
      start    = 1'b0;
      s_tvalid = 1'b0;
   endtask

   logic [DW-1:0] pat;
   logic [SW-1:0] s4_exp;

   initial begin
      rst = 1'b1; start = 1'b0; s_tvalid = 1'b0; s_tdata = '0; base_addr = '0; n_rows = '0;
      for (int i = 0; i < DW/8; i++) pat[i*8 +: 8] = 8'(i);
      s4_exp = 128'h0f0e0d0c0b0a09080706050403020100;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check("reset_busy", 128'(busy), 128'(0));
      check("reset_tready", 128'(s_tready), 128'(0));
      check("reset_vld", 128'(wr_vld_dram), 128'(0));
      rst = 1'b0;
      idle(3);

      // Basic load
      clear_logs();
      cmd(10, 2);
      run_stream(0, pat, 1'b1, -1, -1);
      idle(3);
      check("basic_nwr", 128'(wr_en_log.size()), 128'(4));
      if (wr_en_log.size() == 4) begin
         check("basic_en0", 128'(wr_en_log[0]), 128'h0F);
         check("basic_en1", 128'(wr_en_log[1]), 128'hF0);
         check("basic_en2", 128'(wr_en_log[2]), 128'h0F);
         check("basic_en3", 128'(wr_en_log[3]), 128'hF0);
         check("basic_addr0", 128'(wr_addr_log[0]), 128'd10);
         check("basic_addr1", 128'(wr_addr_log[1]), 128'd10);
         check("basic_addr2", 128'(wr_addr_log[2]), 128'd11);
         check("basic_addr3", 128'(wr_addr_log[3]), 128'd11);
         check("basic_slice4", s4_log[1], s4_exp);
         check("basic_b2b", 128'(wr_cyc[3] - wr_cyc[0]), 128'd3);
         check("basic_first_lat", 128'(wr_cyc[0] - start_cyc), 128'd2);
         check("basic_ndone", 128'(done_log.size()), 128'd1);
         if (done_log.size() == 1) check("basic_done_cyc", 128'(done_log[0]), 128'(wr_cyc[3]));
      end

      // Gapped stream
      clear_logs();
      cmd(10, 2);
      run_stream(1, '0, 1'b0, -1, -1);
      idle(3);
      check("gap_nwr", 128'(wr_cyc.size()), 128'd4);
      if (wr_cyc.size() == 4)
         for (int i = 0; i < 3; i++) check("gap_spacing", 128'(wr_cyc[i+1] - wr_cyc[i]), 128'd3);

      // Address wrap
      clear_logs();
      cmd(4095, 2);
      run_stream(0, '0, 1'b0, -1, -1);
      idle(3);
      check("wrap_nwr", 128'(wr_addr_log.size()), 128'd4);
      if (wr_addr_log.size() == 4) begin
         check("wrap_addr1", 128'(wr_addr_log[1]), 128'd4095);
         check("wrap_addr2", 128'(wr_addr_log[2]), 128'd0);
      end

      // Zero rows
      clear_logs();
      cmd(85, 0);
      idle(4);
      check("zero_nwr", 128'(wr_cyc.size()), 128'd0);
      check("zero_ndone", 128'(done_log.size()), 128'd1);
      if (done_log.size() == 1) check("zero_done_cyc", 128'(done_log[0]), 128'(start_cyc + 1));

      // Ignored start during LOAD
      clear_logs();
      cmd(20, 2);
      run_stream(0, '0, 1'b0, 1, -1);
      idle(4);
      check("ign_nwr", 128'(wr_addr_log.size()), 128'd4);
      if (wr_addr_log.size() == 4) check("ign_addr3", 128'(wr_addr_log[3]), 128'd21);
      check("ign_ndone", 128'(done_log.size()), 128'd1);

      // Reset mid-load, then a fresh one-row load
      clear_logs();
      cmd(30, 4);
      run_stream(0, '0, 1'b0, -1, 3);
      idle(3);
      check("rstl_nwr", 128'(wr_cyc.size()), 128'd3);
      check("rstl_ndone", 128'(done_log.size()), 128'd0);
      clear_logs();
      cmd(40, 1);
      run_stream(2, '0, 1'b0, -1, -1);
      idle(3);
      check("after_nwr", 128'(wr_addr_log.size()), 128'd2);
      if (wr_addr_log.size() == 2) check("after_addr", 128'(wr_addr_log[1]), 128'd40);
      check("after_ndone", 128'(done_log.size()), 128'd1);

      // Randomized commands
      for (int t = 0; t < 10; t++) begin
         cmd(int'($urandom_range(0, RTM_DEPTH - 1)), int'($urandom_range(0, 5)));
         run_stream(2, '0, 1'b0, (t % 3 == 0) ? 2 : -1, -1);
         idle(int'($urandom_range(2, 5)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rtm_dram_loader.md
# rtm_dram_loader

Upstream feeder of the RTM write controller's DRAM port. Accepts a DRAM read-data stream, slices each beat into RTM slice groups and issues one RTM write per beat on wr_vld_dram/wr_en_dram/wr_addr_dram/din_dram. A start command sets the destination base row and the row count. The controller gives the DRAM port top priority, so every issued write lands and this block never sees back-pressure.

## Interface
- S, 8, number of RTM slices
- R, 16, bytes per slice per row
- RTM_DEPTH, 4096, rows per slice; AW = $clog2(RTM_DEPTH)
- DW, 512, stream beat width in bits; S*R*8 must be a multiple of DW, and K = S*R*8/DW must divide S
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- start  input  1  command pulse, sampled in IDLE only
- base_addr  input  AW  first destination row
- n_rows  input  16  rows to load; 0 is legal
- busy  output  1  load in progress
- done  output  1  one-cycle completion pulse
- s_tdata  input  DW  stream data; byte 0 in bits [7:0]
- s_tvalid  input  1  stream valid
- s_tready  output  1  stream ready
- wr_vld_dram  output  1  write request to RTM write controller
- wr_en_dram  output  S  per-slice write enable
- wr_addr_dram  output  S*AW  per-slice row address; field i = bits [i*AW +: AW]
- din_dram  output  S*R*8  per-slice data; slice i = bits [i*R*8 +: R*8]

## Operation
- One row is S*R bytes and takes K beats. With the defaults, K = 2 and G = S/K = 4 slices per beat.
- Beat j of a row (j = 0..K-1) targets slices j*G .. j*G+G-1. Slice j*G+g receives s_tdata[g*R*8 +: R*8].
- For each write:
  - wr_en_dram: set on those G slices only.
  - din_dram: beat data on those slices; all other bits zero.
  - wr_addr_dram: every one of the S fields is (base_addr + row) mod RTM_DEPTH. The address wraps; no error is raised.
- Counters:
  - beat: 0..K-1.
  - row: 0..n_rows-1. It increments when beat wraps from K-1 to 0.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: when start=1, latch base_addr and n_rows and clear the counters. Go to DONE if n_rows = 0, otherwise to LOAD.
  - LOAD: s_tready = 1. Each handshake (s_tvalid & s_tready) issues one write and advances the counters. The handshake of beat K-1 of row n_rows-1 moves the FSM to DONE.
  - DONE: done = 1 for exactly one cycle, then IDLE. s_tready = 0.
- start in LOAD or DONE is ignored, including any base_addr and n_rows on that cycle.
- busy = 1 in LOAD only.
- Stream beats offered while not in LOAD are not consumed (s_tready = 0).

## Timing
- Reset values: s_tready = 0, busy = 0, done = 0, wr_vld_dram = 0, wr_en_dram = 0, wr_addr_dram = 0, din_dram = 0. The FSM resets to IDLE.
- All outputs are registered.
- Write latency: a handshake in cycle t drives wr_vld_dram/wr_en_dram/wr_addr_dram/din_dram in cycle t+1 for exactly one cycle. With no handshake, the next cycle has wr_vld_dram = 0 and wr_en_dram = 0. wr_addr_dram and din_dram keep their last value.
- Throughput: one beat per cycle, sustained, with no bubbles between rows.
- start in cycle t (with n_rows > 0):
  - busy and s_tready are 1 from cycle t+1.
  - The first beat may be accepted in cycle t+1.
- Last handshake in cycle t:
  - The last write and done both appear in cycle t+1.
  - busy and s_tready are 0 in cycle t+1.
  - A new start is accepted from cycle t+2.
- n_rows = 0, start in cycle t: done in cycle t+1 with no write issued, and busy stays 0 throughout.
- rst mid-load:
  - All outputs read their reset values from the next cycle.
  - A write that is pending from the reset cycle's handshake is dropped.
  - The remaining rows are abandoned and no done is issued.

## Test plan
- Basic load: base_addr = 10, n_rows = 2, 4 back-to-back beats with bytes 0x00..0x3F incrementing. Required: four consecutive writes:
  - wr_en_dram = 0x0F then 0xF0, all address fields = 10;
  - then 0x0F, 0xF0 at address 11;
  - slice 4 of write 2 holds beat 2 bytes 0..15;
  - done in the same cycle as the 4th write.
- Gapped stream: the same command with s_tvalid toggling 1,0,0,1,... Required:
  - exactly 4 writes, each one cycle after its handshake;
  - wr_vld_dram = 0 on idle cycles;
  - no duplicate writes.
- Address wrap: base_addr = 4095, n_rows = 2. Required: row 0 is written at address 4095 and row 1 at address 0.
- Zero rows: start with n_rows = 0. Required:
  - done one cycle later;
  - wr_vld_dram never asserts;
  - s_tready stays 0.
- Ignored start: a second start with base_addr = 100 arrives during LOAD. Required: the addresses and the row count of the first command are unchanged, and only one done is produced.
- Reset mid-load: assert rst after 3 of 8 beats. Required:
  - outputs read their reset values on the next cycle;
  - no done;
  - a fresh start afterwards with n_rows = 1 completes normally.
